// File: rtl/interp_fir_stream.sv
// interp_fir_stream: streaming L-phase polyphase interpolation FIR.
// Each accepted sample is shifted into a TAPS-deep delay line. One output per
// phase follows, each computed from that phase's row of the coefficient RAM,
// then rounded half-up and saturated to the sample width.
module interp_fir_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int TAPS       = 7,
   parameter int L          = 2,
   parameter int COEF_WIDTH = 9,
   parameter int SHIFT      = 7,
   localparam int SW = DATA_WIDTH + 2,
   localparam int PW = (L > 1) ? $clog2(L) : 1,
   localparam int AW = (L * TAPS > 1) ? $clog2(L * TAPS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [SW-1:0]         in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [SW-1:0]         out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PW-1:0]                out_phase,
   input  logic                         coef_we,
   input  logic [AW-1:0]                coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output logic                         sat_flag
);

   localparam int PRW = SW + COEF_WIDTH;
   localparam int ACW = SW + COEF_WIDTH + $clog2(TAPS);
   // One extra bit so adding the rounding constant can never wrap.
   localparam int RW  = ACW + 1;
   localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
   localparam logic signed [RW-1:0] MAXV = RW'(2 ** (SW - 1) - 1);
   localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (SW - 1)));

   typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

   state_t                       state, state_nxt;
   logic [PW-1:0]                phase;
   logic signed [SW-1:0]         x    [TAPS];
   logic signed [COEF_WIDTH-1:0] coef [L][TAPS];
   logic signed [PRW-1:0]        prod [TAPS];
   logic signed [ACW-1:0]        acc;
   logic signed [RW-1:0]         rnd;
   logic signed [SW-1:0]         res;
   logic                         res_sat;
   logic                         accept;
   logic                         last_phase;

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == HOLD);
   assign accept     = (state == IDLE) && in_valid;
   assign last_phase = (phase == PW'(L - 1));

   // Per-tap products for the current phase; operands widened first so the
   // multiply happens at full product width.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign prod[k] = PRW'(coef[phase][k]) * PRW'(x[k]);
   end

   // Sum of all tap products; width is sized so it cannot overflow.
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + ACW'(prod[k]);
   end

   // Round half up (arithmetic shift), then clamp to the sample range.
   always_comb begin
      rnd     = (RW'(acc) + HALF) >>> SHIFT;
      res     = SW'(rnd);
      res_sat = 1'b0;
      if (rnd > MAXV) begin
         res     = SW'(MAXV);
         res_sat = 1'b1;
      end else if (rnd < MINV) begin
         res     = SW'(MINV);
         res_sat = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: one COMPUTE cycle per phase, then HOLD until the handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = COMPUTE;
         COMPUTE: state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = last_phase ? IDLE : COMPUTE;
         default: state_nxt = IDLE;
      endcase
   end

   // Coefficient RAM: writable only while idle; out-of-range addresses match
   // no entry and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < L; p++)
            for (int k = 0; k < TAPS; k++) coef[p][k] <= '0;
      end else if (state == IDLE && coef_we) begin
         for (int p = 0; p < L; p++)
            for (int k = 0; k < TAPS; k++)
               if (coef_addr == AW'(p * TAPS + k)) coef[p][k] <= coef_data;
      end
   end

   // Delay line, phase counter and registered output sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) x[k] <= '0;
         phase     <= '0;
         out_data  <= '0;
         out_phase <= '0;
         sat_flag  <= 1'b0;
      end else begin
         if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0]  <= in_data;
            phase <= '0;
         end
         if (state == COMPUTE) begin
            out_data  <= res;
            out_phase <= phase;
            sat_flag  <= res_sat;
         end
         if (state == HOLD && out_ready) begin
            sat_flag <= 1'b0;
            if (!last_phase) phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_interp_fir_stream.sv
// Bench for interp_fir_stream: expected samples are pushed when an input is
// accepted and popped as each output handshake completes.
module tb_interp_fir_stream;

   localparam int DW = 8, TAPS = 7, L = 2, CW = 9, SHIFT = 7;
   localparam int SW = DW + 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic signed [SW-1:0] in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [SW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [0:0]           out_phase;
   logic                 coef_we = 1'b0;
   logic [3:0]           coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic                 sat_flag;

   int checks = 0;
   int errors = 0;

   typedef struct {int data; int phase; bit sat;} exp_t;
   exp_t q[$];

   int mcoef [L][TAPS];
   int mx    [TAPS];

   interp_fir_stream #(.DATA_WIDTH(DW), .TAPS(TAPS), .L(L), .COEF_WIDTH(CW), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_phase(out_phase),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic void model_clear();
      for (int p = 0; p < L; p++) for (int k = 0; k < TAPS; k++) mcoef[p][k] = 0;
      for (int k = 0; k < TAPS; k++) mx[k] = 0;
      q.delete();
   endfunction

   function automatic void push_exp(input int d, input int p, input bit s);
      exp_t e;
      e.data = d; e.phase = p; e.sat = s;
      q.push_back(e);
   endfunction

   // Shift the reference delay line; optionally predict all phases by plain arithmetic.
   function automatic void model_accept(input int d, input bit auto_exp);
      longint a, r;
      bit s;
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      if (auto_exp) begin
         for (int p = 0; p < L; p++) begin
            a = 0;
            for (int k = 0; k < TAPS; k++) a += longint'(mcoef[p][k]) * longint'(mx[k]);
            r = (a + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
            s = 0;
            if (r > 511) begin r = 511; s = 1; end
            else if (r < -512) begin r = -512; s = 1; end
            push_exp(int'(r), p, s);
         end
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic write_coef(input int addr, input int data);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 9'(data);
      @(posedge clk);
      if (addr < L * TAPS) mcoef[addr / TAPS][addr % TAPS] = data;
      #1 coef_we = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      checks++;
      if (!in_ready) begin errors++; $display("FAIL %s_ready_timeout: in_ready=0, required 1", tag); end
   endtask

   task automatic send(input int d, input bit auto_exp);
      wait_ready("send");
      in_data = 10'(d); in_valid = 1'b1;
      @(posedge clk);
      model_accept(d, auto_exp);
      #1 in_valid = 1'b0;
   endtask

   // Coefficient write and sample presented in the same idle cycle.
   task automatic send_with_write(input int addr, input int cdata, input int d);
      wait_ready("send_w");
      coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 9'(cdata);
      in_data = 10'(d); in_valid = 1'b1;
      @(posedge clk);
      if (addr < L * TAPS) mcoef[addr / TAPS][addr % TAPS] = cdata;
      model_accept(d, 1'b1);
      #1 begin coef_we = 1'b0; in_valid = 1'b0; end
   endtask

   task automatic wait_valid(input string tag, output bit ok);
      int w = 0;
      @(negedge clk);
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      checks++;
      ok = out_valid;
      if (!out_valid) begin errors++; $display("FAIL %s_valid_timeout: out_valid=0, required 1", tag); end
   endtask

   // Take n outputs, comparing each against the head of the expectation queue.
   task automatic collect(input int n, input string tag);
      exp_t e;
      bit ok;
      for (int i = 0; i < n; i++) begin
         wait_valid(tag, ok);
         if (!ok) return;
         checks++;
         if (q.size() == 0) begin
            errors++; $display("FAIL %s_unexpected: out_data=%0d with no expected sample", tag, out_data);
         end else begin
            e = q.pop_front();
            checks++;
            if (int'(out_data) !== e.data) begin
               errors++; $display("FAIL %s_data[%0d]: got %0d, required %0d", tag, i, out_data, e.data);
            end
            checks++;
            if (int'(out_phase) !== e.phase) begin
               errors++; $display("FAIL %s_phase[%0d]: got %0d, required %0d", tag, i, out_phase, e.phase);
            end
            checks++;
            if (sat_flag !== e.sat) begin
               errors++; $display("FAIL %s_sat[%0d]: got %0b, required %0b", tag, i, sat_flag, e.sat);
            end
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic load_basic_coefs();
      for (int a = 0; a < L * TAPS; a++) write_coef(a, 0);
      write_coef(0, 128);
      write_coef(7, 64);
      write_coef(8, 64);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      checks++; if (out_data !== 10'sd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
      checks++; if (out_phase !== 1'b0) begin errors++; $display("FAIL reset_out_phase: got %0d, required 0", out_phase); end
      checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %0b, required 0", sat_flag); end
   endtask

   task automatic test_basic();
      load_basic_coefs();
      send(100, 1'b0);
      push_exp(100, 0, 0); push_exp(50, 1, 0);
      // Accepting edge E: after it the block is computing, after E+1 it presents.
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid=%0b, required 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: in_ready=%0b, required 0", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%0b, required 1", out_valid); end
      collect(2, "basic0");
      send(200, 1'b0);
      push_exp(200, 0, 0); push_exp(150, 1, 0);
      collect(2, "basic1");
   endtask

   task automatic test_saturation();
      do_reset();
      write_coef(0, 255);
      write_coef(1, 255);
      send(511, 1'b0);  push_exp(511, 0, 1);  push_exp(0, 1, 0); collect(2, "sat_pos1");
      send(511, 1'b0);  push_exp(511, 0, 1);  push_exp(0, 1, 0); collect(2, "sat_pos2");
      send(-512, 1'b0); push_exp(-2, 0, 0);   push_exp(0, 1, 0); collect(2, "sat_neg1");
      send(-512, 1'b0); push_exp(-512, 0, 1); push_exp(0, 1, 0); collect(2, "sat_neg2");
   endtask

   task automatic test_backpressure();
      logic signed [SW-1:0] d0;
      logic [0:0] p0;
      bit ok;
      load_basic_coefs();
      send(30, 1'b1);
      wait_valid("bp", ok);
      d0 = out_data; p0 = out_phase;
      in_data = 10'sd77; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_data !== d0) begin errors++; $display("FAIL bp_data_stable[%0d]: got %0d, required %0d", i, out_data, d0); end
         checks++; if (out_phase !== p0) begin errors++; $display("FAIL bp_phase_stable[%0d]: got %0d, required %0d", i, out_phase, p0); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b, required 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %0b, required 1", i, out_valid); end
      end
      collect(2, "bp_first");
      // 77 has been held throughout; it is taken at the first edge after the last handshake.
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_point: in_ready=%0b, required 1", in_ready); end
      @(posedge clk);
      model_accept(77, 1'b1);
      #1 in_valid = 1'b0;
      collect(2, "bp_second");
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      send(100, 1'b1);
      wait_valid("rst_mid", ok);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %0b, required 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %0b, required 1", in_ready); end
      checks++; if (out_phase !== 1'b0) begin errors++; $display("FAIL rst_mid_out_phase: got %0d, required 0", out_phase); end
      send(100, 1'b0);
      push_exp(0, 0, 0); push_exp(0, 1, 0);
      collect(2, "rst_mid_after");
   endtask

   task automatic test_coef_busy();
      bit ok;
      load_basic_coefs();
      send(40, 1'b1);
      wait_valid("busy", ok);
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 9'sd1;
      @(posedge clk); #1;
      coef_we = 1'b0;
      collect(2, "busy_hold");
      send(100, 1'b0);
      push_exp(100, 0, 0); push_exp(70, 1, 0);
      collect(2, "busy_after");
      // Out-of-range address must not alias onto a real coefficient.
      write_coef(14, 1);
      send(100, 1'b1);
      collect(2, "addr_oob");
      send_with_write(0, 64, 100);
      checks++;
      if (q.size() < 1 || q[0].data !== 50) begin errors++; $display("FAIL simul_write_model: model phase0 not 50"); end
      collect(2, "simul_write");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_reset_mid_burst();
      test_coef_busy();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL leftover_expected: %0d outputs never produced, required 0", q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
